// File: rtl/gray2rgb_ser.sv
`default_nettype none
// ============================================================================
// Module   : gray2rgb_ser
// Purpose  : Expands one gray pixel into an R,G,B triple (replicated gray or
//            heat map) and streams it as three byte-serial channel beats.
// Revision : 1.0 - initial release
// ============================================================================
module gray2rgb_ser #(
    parameter int width_p        = 8,
    parameter int frame_pixels_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] gray_i,
    input  logic               mode_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    output logic [1:0]         chan_o,
    output logic               last_o,
    input  logic               ready_i
);

    localparam int PIX_W = (frame_pixels_p > 1) ? $clog2(frame_pixels_p) : 1;
    localparam logic [PIX_W-1:0] c_last_pix = PIX_W'(frame_pixels_p - 1);

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    chan_e              chan_q, chan_d;
    logic               valid_q, valid_d;
    logic [width_p-1:0] red_q, red_d;
    logic [width_p-1:0] grn_q, grn_d;
    logic [width_p-1:0] blu_q, blu_d;
    logic [PIX_W-1:0]   pix_q, pix_d;

    logic               w_fire;
    logic               w_b_done;
    logic               w_accept;
    logic               w_below;
    logic [width_p-1:0] w_dbl;
    logic [width_p-1:0] w_red;
    logic [width_p-1:0] w_grn;
    logic [width_p-1:0] w_blu;

    assign w_fire   = valid_q & ready_i;
    assign w_b_done = w_fire & (chan_q == CH_B);
    assign ready_o  = ~valid_q | ((chan_q == CH_B) & ready_i);
    assign w_accept = valid_i & ready_o;

    // Heat map: the MSB decides the half; doubling the low bits covers both
    // g<<1 in the lower half and (g-H)<<1 in the upper half.
    assign w_below = ~gray_i[width_p-1];
    assign w_dbl   = {gray_i[width_p-2:0], 1'b0};

    always_comb begin
        w_red = gray_i;
        w_grn = gray_i;
        w_blu = gray_i;
        if (mode_i) begin
            w_red = w_below ? w_dbl : {width_p{1'b1}};
            w_grn = w_below ? {width_p{1'b0}} : w_dbl;
            w_blu = ~gray_i;
        end
    end

    always_comb begin
        valid_d = valid_q;
        chan_d  = chan_q;
        red_d   = red_q;
        grn_d   = grn_q;
        blu_d   = blu_q;
        pix_d   = pix_q;
        if (w_b_done) begin
            valid_d = 1'b0;
            chan_d  = CH_R;
            pix_d   = (pix_q == c_last_pix) ? '0 : pix_q + PIX_W'(1);
        end else if (w_fire) begin
            chan_d = (chan_q == CH_R) ? CH_G : CH_B;
        end
        // A new pixel may land in the same cycle its predecessor's B beat leaves.
        if (w_accept) begin
            valid_d = 1'b1;
            chan_d  = CH_R;
            red_d   = w_red;
            grn_d   = w_grn;
            blu_d   = w_blu;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            chan_q  <= CH_R;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
            pix_q   <= '0;
        end else begin
            valid_q <= valid_d;
            chan_q  <= chan_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        data_o = red_q;
        case (chan_q)
            CH_G:    data_o = grn_q;
            CH_B:    data_o = blu_q;
            default: data_o = red_q;
        endcase
    end

    assign valid_o = valid_q;
    assign chan_o  = chan_q;
    assign last_o  = valid_q & (chan_q == CH_B) & (pix_q == c_last_pix);

endmodule
`default_nettype wire

// File: tb/tb_gray2rgb_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray2rgb_ser
// Purpose  : Self-checking bench for gray2rgb_ser against a beat-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray2rgb_ser;

    localparam int W = 8;
    localparam int F = 4;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic [W-1:0] gray_i;
    logic         mode_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic [1:0]   chan_o;
    logic         last_o;
    logic         ready_i;

    gray2rgb_ser #(.width_p(W), .frame_pixels_p(F)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .gray_i  (gray_i),
        .mode_i  (mode_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .chan_o  (chan_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t        q[$];
    int           acc_cnt;
    int           n_cmp;
    int           n_err;
    bit           pend;
    logic         exp_valid;
    logic         exp_ready;
    logic [12:0]  exp_vec;
    logic [12:0]  obs_vec;

    function automatic logic [W-1:0] ref_chan(input int g, input logic m, input int c);
        int h;
        int mx;
        int v;
        h  = 1 << (W - 1);
        mx = (1 << W) - 1;
        if (!m) v = g;
        else if (c == 0) v = (g < h) ? 2 * g : mx;
        else if (c == 1) v = (g < h) ? 0 : 2 * (g - h);
        else v = mx - g;
        return W'(v);
    endfunction

    // Applies the clock edge just passed to the model, using the inputs that were held.
    task automatic advance();
        beat_t b;
        if (exp_valid && ready_i) void'(q.pop_front());
        if (valid_i && exp_ready) begin
            for (int c = 0; c < 3; c++) begin
                b.ch = 2'(c);
                b.d  = ref_chan(int'(gray_i), mode_i, c);
                b.l  = (c == 2) && ((acc_cnt % F) == F - 1);
                q.push_back(b);
            end
            acc_cnt++;
        end
    endtask

    task automatic apply(input logic vi, input logic [W-1:0] g, input logic m, input logic ri);
        if (pend) advance();
        @(negedge clk_i);
        valid_i = vi;
        gray_i  = g;
        mode_i  = m;
        ready_i = ri;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (q.size() == 1 && ri);
        exp_vec   = {exp_valid, exp_ready, 11'b0};
        if (exp_valid) exp_vec = {1'b1, exp_ready, q[0].l, q[0].ch, q[0].d};
        obs_vec = {valid_o, ready_o, last_o,
                   exp_valid ? chan_o : 2'b00, exp_valid ? data_o : {W{1'b0}}};
        pend = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        q.delete();
        acc_cnt = 0;
        pend    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({valid_o, chan_o, data_o, last_o} !== {1'b0, 2'd0, {W{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: valid/chan/data/last=%b/%0d/%h/%b required 0/0/00/0",
                     valid_o, chan_o, data_o, last_o);
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            n_cmp++;
            if ({valid_o, ready_o, last_o} !== 3'b010) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: valid/ready/last=%b%b%b required 010",
                         i, valid_o, ready_o, last_o);
            end
        end
    endtask

    task automatic test_mode0();
        apply(1'b1, 8'h40, 1'b0, 1'b1);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL mode0_accept: ready_o=%b required 1", ready_o);
        end
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, '0, 1'b1, 1'b1);
            n_cmp++;
            if ({valid_o, chan_o, data_o} !== {1'b1, 2'(c), 8'h40}) begin
                n_err++;
                $display("FAIL mode0_beat%0d: valid/chan/data=%b/%0d/%h required 1/%0d/40",
                         c, valid_o, chan_o, data_o, c);
            end
        end
        apply(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if ({valid_o, chan_o} !== 3'b000) begin
            n_err++;
            $display("FAIL mode0_drain: valid/chan=%b/%0d required 0/0", valid_o, chan_o);
        end
    endtask

    task automatic test_heatmap();
        logic [W-1:0] gt [8];
        logic [W-1:0] et [8][3];
        gt[0] = 8'h40; et[0][0] = 8'h80; et[0][1] = 8'h00; et[0][2] = 8'hBF;
        gt[1] = 8'hC0; et[1][0] = 8'hFF; et[1][1] = 8'h80; et[1][2] = 8'h3F;
        gt[2] = 8'h80; et[2][0] = 8'hFF; et[2][1] = 8'h00; et[2][2] = 8'h7F;
        gt[3] = 8'hFF; et[3][0] = 8'hFF; et[3][1] = 8'hFE; et[3][2] = 8'h00;
        for (int p = 4; p < 8; p++) begin
            gt[p] = W'($urandom_range(0, 255));
            for (int c = 0; c < 3; c++) et[p][c] = ref_chan(int'(gt[p]), 1'b1, c);
        end
        for (int p = 0; p < 8; p++) begin
            apply(1'b1, gt[p], 1'b1, 1'b1);
            for (int c = 0; c < 3; c++) begin
                apply(1'b0, '0, 1'b0, 1'b1);
                n_cmp++;
                if ({valid_o, chan_o, data_o} !== {1'b1, 2'(c), et[p][c]}) begin
                    n_err++;
                    $display("FAIL heat g=%h ch%0d: valid/chan/data=%b/%0d/%h required 1/%0d/%h",
                             gt[p], c, valid_o, chan_o, data_o, c, et[p][c]);
                end
            end
        end
    endtask

    task automatic test_back_to_back(input int npix);
        int sent;
        int beats;
        int first;
        int lastc;
        int lasts;
        sent = 0; beats = 0; first = -1; lastc = -1; lasts = 0;
        for (int c = 0; c < npix * 3 + 3; c++) begin
            apply(sent < npix, W'($urandom_range(0, 255)), 1'($urandom), 1'b1);
            if (valid_i && exp_ready) sent++;
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL b2b cyc%0d: v/r/l/ch/d=%h required %h", c, obs_vec, exp_vec);
            end
            if (valid_o) begin
                beats++;
                if (first < 0) first = c;
                lastc = c;
                if (last_o) begin
                    lasts++;
                    n_cmp++;
                    if ((beats % 12) != 0) begin
                        n_err++;
                        $display("FAIL b2b_last_pos: last_o at beat %0d required multiple of 12", beats);
                    end
                end
            end
        end
        n_cmp++;
        if (beats != npix * 3 || (lastc - first) != npix * 3 - 1 || lasts != npix / 4) begin
            n_err++;
            $display("FAIL b2b_stream: beats/span/lasts=%0d/%0d/%0d required %0d/%0d/%0d",
                     beats, lastc - first + 1, lasts, npix * 3, npix * 3, npix / 4);
        end
    endtask

    task automatic test_random_stall();
        for (int c = 0; c < 400; c++) begin
            apply(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_err++;
                $display("FAIL stall cyc%0d: v/r/l/ch/d=%h required %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            apply(1'b1, W'($urandom_range(0, 255)), 1'($urandom), 1'b1);
            repeat (3) apply(1'b0, '0, 1'b0, 1'b1);
        end
        apply(1'b1, 8'h33, 1'b1, 1'b1);
        apply(1'b0, '0, 1'b0, 1'b1);
        apply(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if ({valid_o, chan_o} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL rstmid_g: valid/chan=%b/%0d required 1/1", valid_o, chan_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++;
        if ({valid_o, ready_o, last_o} !== 3'b010) begin
            n_err++;
            $display("FAIL rstmid_drop: valid/ready/last=%b%b%b required 010",
                     valid_o, ready_o, last_o);
        end
        reset_i = 1'b0;
        q.delete();
        acc_cnt = 0;
        pend    = 1'b0;
        test_back_to_back(4);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        acc_cnt = 0;
        pend    = 1'b0;
        reset_i = 1'b1;
        valid_i = 1'b0;
        gray_i  = '0;
        mode_i  = 1'b0;
        ready_i = 1'b0;
        test_reset();
        test_mode0();
        test_heatmap();
        do_reset();
        test_back_to_back(8);
        test_random_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
